// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-stage instruction fetch with PC, IF/ID register, fetch
//            fault detection and a fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_exc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // 33-bit bounds so RESET_PC + 4*IM_WORDS cannot wrap past 2^32
  localparam logic [32:0] C_PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] C_PC_HI = C_PC_LO + (33'(IM_WORDS) << 2);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] id_pc_n;
  logic [31:0] id_instr_n;
  logic        exc_n;
  logic [31:0] count_n;
  logic        pc_bad;

  assign im_pc  = pc;
  assign pc_bad = (pc[1:0] != 2'b00)
               || ({1'b0, pc} <  C_PC_LO)
               || ({1'b0, pc} >= C_PC_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_instr <= 32'd0;
      if_id_exc   <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_valid <= valid_n;
      if_id_pc    <= id_pc_n;
      if_id_instr <= id_instr_n;
      if_id_exc   <= exc_n;
      fetch_count <= count_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    valid_n    = if_id_valid;
    id_pc_n    = if_id_pc;
    id_instr_n = if_id_instr;
    exc_n      = if_id_exc;
    count_n    = fetch_count;

    if (state != BOOT && redirect_valid) begin
      // Redirect outranks stall and fault: flush IF/ID and restart fetching
      state_n    = RUN;
      pc_n       = redirect_pc;
      valid_n    = 1'b0;
      id_pc_n    = 32'd0;
      id_instr_n = 32'd0;
      exc_n      = 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state_n = RUN;
        end
        RUN: begin
          if (!stall) begin
            valid_n = 1'b1;
            id_pc_n = pc;
            if (pc_bad) begin
              id_instr_n = 32'd0;
              exc_n      = 1'b1;
              state_n    = FAULT;
            end else begin
              id_instr_n = im_instr;
              exc_n      = 1'b0;
              pc_n       = pc + 32'd4;
              count_n    = fetch_count + 32'd1;
            end
          end
        end
        FAULT: begin
          valid_n    = 1'b0;
          id_instr_n = 32'd0;
          exc_n      = 1'b0;
        end
        default: begin
          state_n = BOOT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed, table-driven bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_exc;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .IM_WORDS (4096)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_pc          (im_pc),
    .im_instr       (im_instr),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_exc      (if_id_exc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory word i at byte address 0x3000 + 4*i holds 0x1000_0000 + i
  assign im_instr = 32'h1000_0000 + ((im_pc - 32'h0000_3000) >> 2);

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_im_pc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_exc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic rv, input logic [31:0] rpc,
                     input logic [31:0] ipc, input logic v, input logic [31:0] p,
                     input logic [31:0] ins, input logic e, input logic [31:0] c);
    vec_t t;
    t = '{s, rv, rpc, ipc, v, p, ins, e, c};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ipc, input logic v,
                         input logic [31:0] p, input logic [31:0] ins,
                         input logic e, input logic [31:0] c);
    chk({tag, ".im_pc"},       im_pc,               ipc);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".if_id_pc"},    if_id_pc,            p);
    chk({tag, ".if_id_instr"}, if_id_instr,         ins);
    chk({tag, ".if_id_exc"},   {31'd0, if_id_exc},  {31'd0, e});
    chk({tag, ".fetch_count"}, fetch_count,         c);
  endtask

  task automatic edge_step(input logic s, input logic rv, input logic [31:0] rpc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // BOOT edge, then sequential fetch from 0x3000
    add(0, 0, 0,            32'h3000, 0, 32'h0,    32'h0,        0, 0);
    add(0, 0, 0,            32'h3004, 1, 32'h3000, 32'h10000000, 0, 1);
    add(0, 0, 0,            32'h3008, 1, 32'h3004, 32'h10000001, 0, 2);
    add(0, 0, 0,            32'h300C, 1, 32'h3008, 32'h10000002, 0, 3);
    add(0, 0, 0,            32'h3010, 1, 32'h300C, 32'h10000003, 0, 4);
    // Redirect wins over stall, then stall alone holds for 3 edges
    add(1, 1, 32'h3100,     32'h3100, 0, 32'h0,    32'h0,        0, 4);
    add(1, 0, 0,            32'h3100, 0, 32'h0,    32'h0,        0, 4);
    add(1, 0, 0,            32'h3100, 0, 32'h0,    32'h0,        0, 4);
    add(1, 0, 0,            32'h3100, 0, 32'h0,    32'h0,        0, 4);
    add(0, 0, 0,            32'h3104, 1, 32'h3100, 32'h10000040, 0, 5);
    // Misaligned redirect faults, FAULT idles regardless of stall
    add(0, 1, 32'h3102,     32'h3102, 0, 32'h0,    32'h0,        0, 5);
    add(0, 0, 0,            32'h3102, 1, 32'h3102, 32'h0,        1, 5);
    add(0, 0, 0,            32'h3102, 0, 32'h3102, 32'h0,        0, 5);
    add(1, 0, 0,            32'h3102, 0, 32'h3102, 32'h0,        0, 5);
    add(0, 0, 0,            32'h3102, 0, 32'h3102, 32'h0,        0, 5);
    add(1, 0, 0,            32'h3102, 0, 32'h3102, 32'h0,        0, 5);
    add(0, 1, 32'h3000,     32'h3000, 0, 32'h0,    32'h0,        0, 5);
    add(0, 0, 0,            32'h3004, 1, 32'h3000, 32'h10000000, 0, 6);
    // Range bounds
    add(0, 1, 32'h6FFC,     32'h6FFC, 0, 32'h0,    32'h0,        0, 6);
    add(0, 0, 0,            32'h7000, 1, 32'h6FFC, 32'h10000FFF, 0, 7);
    add(0, 0, 0,            32'h7000, 1, 32'h7000, 32'h0,        1, 7);
    add(0, 1, 32'h2FFC,     32'h2FFC, 0, 32'h0,    32'h0,        0, 7);
    add(0, 0, 0,            32'h2FFC, 1, 32'h2FFC, 32'h0,        1, 7);
    add(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0, 32'h0,       0, 7);
    add(0, 0, 0,            32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h0, 1, 7);
    // Return to a stalled RUN with fetch_count=7
    add(1, 1, 32'h3010,     32'h3010, 0, 32'h0,    32'h0,        0, 7);
    add(1, 0, 0,            32'h3010, 0, 32'h0,    32'h0,        0, 7);

    // Reset asserted asynchronously before any clock edge
    #1 reset = 1'b0;
    #1 chk_all("reset0", 32'h3000, 0, 0, 0, 0, 0);
    #10 reset = 1'b1;

    foreach (vecs[i]) begin
      edge_step(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_im_pc, vecs[i].e_valid,
              vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_exc, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-cycle during stalled RUN: clears before next edge
    #1 reset = 1'b0;
    #1 chk_all("async_rst", 32'h3000, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;

    // BOOT edge ignores a redirect; then first fetch is 0x3000
    edge_step(0, 1, 32'h3100);
    chk_all("boot_redir", 32'h3000, 0, 0, 0, 0, 0);
    edge_step(0, 0, 0);
    chk_all("post_rst", 32'h3004, 1, 32'h3000, 32'h10000000, 0, 1);

    // Counter wrap
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1 release dut.fetch_count;
    edge_step(0, 0, 0);
    chk_all("cnt_wrap", 32'h3008, 1, 32'h3004, 32'h10000001, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
